wshb_ram_responder: RTL

- Wishbone responder (slave) that answers the 16-bit master port used by the display and pattern-generation blocks.
- Backed by an on-chip synchronous RAM; serves as the frame-buffer target in simulation and in small-resolution builds without SDRAM.
- Supports classic single cycles and linear incrementing bursts (cti=3'b010, bte=2'b00), with programmable read wait states.
- Flags out-of-range addresses with err.

---
 rtl/wshb_pkg.sv | 33 +++
 rtl/wshb_if_DATA_BYTES_2_ADDRESS_WIDTH_32.sv | 28 ++
 rtl/ram_be_sp.sv | 34 +++
 rtl/wshb_ram_responder.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/wshb_pkg.sv
// Shared types for the 16-bit Wishbone RAM responder.
// Cycle-type tags, burst types, FSM states and a range helper.
package wshb_pkg;

    typedef enum logic [2:0] {
        CTI_CLASSIC = 3'b000,
        CTI_CONST   = 3'b001,
        CTI_INCR    = 3'b010,
        CTI_END     = 3'b111
    } cti_t;

    typedef enum logic [1:0] {
        BTE_LINEAR = 2'b00,
        BTE_WRAP4  = 2'b01,
        BTE_WRAP8  = 2'b10,
        BTE_WRAP16 = 2'b11
    } bte_t;

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        WACK,
        RWAIT,
        RACK,
        ERR
    } state_t;

    // Full-width compare so high address bits are never truncated away.
    function automatic logic oob(input logic [31:0] i, input int unsigned d);
        return i >= d;
    endfunction

endpackage

// File: rtl/wshb_if_DATA_BYTES_2_ADDRESS_WIDTH_32.sv
// Wishbone bus bundle: 16-bit data, 32-bit byte address.
// The master drives the request fields, the slave the response.
interface wshb_if_DATA_BYTES_2_ADDRESS_WIDTH_32 (
    input logic clk
);
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [15:0] dat_ms;
    logic [15:0] dat_sm;
    logic [1:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        input  clk, dat_sm, ack, err, rty,
        output cyc, stb, we, adr, dat_ms, sel, cti, bte
    );

    modport slave (
        input  clk, cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output dat_sm, ack, err, rty
    );
endinterface

// File: rtl/ram_be_sp.sv
// Single-port synchronous RAM, 16-bit words with byte enables.
// Registered read output, updated only on read accesses.
module ram_be_sp #(
    parameter int DEPTH = 76800,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic          we,
    input  logic [1:0]    be,
    input  logic [AW-1:0] addr,
    input  logic [15:0]   wdata,
    output logic [15:0]   rdata
);

    logic [15:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en && we) begin
            if (be[0]) mem[addr][7:0]  <= wdata[7:0];
            if (be[1]) mem[addr][15:8] <= wdata[15:8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (en && !we) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/wshb_ram_responder.sv
// Wishbone responder backed by on-chip RAM: classic and linear
// incrementing bursts, programmable read wait states, err on range.
module wshb_ram_responder
    import wshb_pkg::*;
#(
    parameter int DEPTH     = 76800,
    parameter int RD_WAIT   = 0,
    parameter bit INIT_ZERO = 1
) (
    input logic CLK,
    input logic RST,
    wshb_if_DATA_BYTES_2_ADDRESS_WIDTH_32.slave wb_s
);

    localparam int AW = $clog2(DEPTH);

    state_t        state;
    state_t        state_nx;
    logic [AW-1:0] clr_cnt;
    logic [1:0]    wait_cnt;
    logic [31:0]   idx;
    logic [31:0]   idx_nx;
    logic          busy;
    logic          req;
    logic          burst;
    logic          ram_en;
    logic          ram_we;
    logic [1:0]    ram_be;
    logic [AW-1:0] ram_addr;
    logic [15:0]   ram_wdata;
    logic [15:0]   ram_rdata;
    logic          unused_bits;

    assign idx    = {1'b0, wb_s.adr[31:1]};
    assign idx_nx = idx + 32'd1;
    assign busy   = wb_s.cyc && wb_s.stb;
    assign req    = busy && !wb_s.ack && !wb_s.err;
    assign burst  = (wb_s.cti == CTI_INCR) && (wb_s.bte == BTE_LINEAR);

    assign wb_s.ack    = (state == WACK) || (state == RACK);
    assign wb_s.err    = (state == ERR);
    assign wb_s.rty    = 1'b0;
    assign wb_s.dat_sm = ram_rdata;
    assign unused_bits = ^{wb_s.clk, wb_s.adr[0]};

    always_ff @(posedge CLK) begin
        if (RST) begin
            if (INIT_ZERO) state <= CLEAR;
            else           state <= IDLE;
            clr_cnt  <= '0;
            wait_cnt <= '0;
        end else begin
            state    <= state_nx;
            clr_cnt  <= (state == CLEAR) ? clr_cnt + AW'(1) : clr_cnt;
            wait_cnt <= (state == RWAIT) ? wait_cnt + 2'd1 : 2'd0;
        end
    end

    always_comb begin
        state_nx  = state;
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_be    = wb_s.sel;
        ram_addr  = idx[AW-1:0];
        ram_wdata = wb_s.dat_ms;
        unique case (state)
            CLEAR: begin
                ram_en    = 1'b1;
                ram_we    = 1'b1;
                ram_be    = 2'b11;
                ram_addr  = clr_cnt;
                ram_wdata = '0;
                if (clr_cnt == AW'(DEPTH - 1)) state_nx = IDLE;
            end
            IDLE: begin
                if (req) begin
                    if (oob(idx, DEPTH)) begin
                        state_nx = ERR;
                    end else if (wb_s.we) begin
                        ram_en   = 1'b1;
                        ram_we   = 1'b1;
                        state_nx = WACK;
                    end else if (RD_WAIT == 0) begin
                        ram_en   = 1'b1;
                        state_nx = RACK;
                    end else begin
                        state_nx = RWAIT;
                    end
                end
            end
            WACK: begin
                // The beat on the bus is (re)written as its ack cycle ends.
                if (!busy) begin
                    state_nx = IDLE;
                end else begin
                    ram_en = 1'b1;
                    ram_we = wb_s.we;
                    if (!burst)                state_nx = IDLE;
                    else if (oob(idx_nx, DEPTH)) state_nx = ERR;
                    else                       state_nx = WACK;
                end
            end
            RWAIT: begin
                if (!busy) begin
                    state_nx = IDLE;
                end else if (wait_cnt == 2'(RD_WAIT - 1)) begin
                    ram_en   = 1'b1;
                    state_nx = RACK;
                end
            end
            RACK: begin
                // Prefetch the next word so burst beats need no wait.
                if (!busy || !burst) begin
                    state_nx = IDLE;
                end else if (oob(idx_nx, DEPTH)) begin
                    state_nx = ERR;
                end else begin
                    ram_en   = 1'b1;
                    ram_addr = idx_nx[AW-1:0];
                    state_nx = RACK;
                end
            end
            ERR: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    ram_be_sp #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clk  (CLK),
        .rst  (RST),
        .en   (ram_en && !RST),
        .we   (ram_we && !RST),
        .be   (ram_be),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

endmodule
